intr_controller: RTL

//  Memory-mapped interrupt controller downstream of the timer and other peripherals.

---
 rtl/intr_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/intr_controller.sv
// rtl/intr_controller.sv - memory-mapped interrupt controller with edge latching, masking and claim/EOI
module intr_controller #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CS_N,
    input  logic               RD_N,
    input  logic               WR_N,
    input  logic [11:0]        Addr,
    input  logic [31:0]        DataIn,
    output logic [31:0]        DataOut,
    input  logic [NUM_SRC-1:0] IntrSrc_N,
    output logic               IRQ_N
);

    localparam logic [11:0] ADDR_PEND   = 12'h000;
    localparam logic [11:0] ADDR_ENABLE = 12'h100;
    localparam logic [11:0] ADDR_VECTOR = 12'h200;
    localparam logic [11:0] ADDR_EOI    = 12'h300;
    localparam logic [11:0] ADDR_STATE  = 12'h400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] prev_src_q;
    logic [4:0]         in_service_q, in_service_d;
    logic               irq_n_q;
    logic [31:0]        data_out_q, data_out_d;

    logic [NUM_SRC-1:0] pend_set;
    logic [NUM_SRC-1:0] active;
    logic               any_active;
    logic [4:0]         idx;
    logic               rd_en, wr_en;
    logic               claim;
    logic               eoi;
    logic [31:0]        rdata;
    logic               unused_data_hi;

    assign pend_set   = prev_src_q & ~IntrSrc_N;
    assign active     = pend_q & enable_q;
    assign any_active = |active;
    assign rd_en      = ~CS_N & ~RD_N;
    assign wr_en      = ~CS_N & ~WR_N;
    assign claim      = rd_en && (Addr == ADDR_VECTOR) && (state_q == ASSERT) && any_active;
    assign eoi        = wr_en && (Addr == ADDR_EOI);

    // Upper write-data bits beyond the source count carry no meaning.
    assign unused_data_hi = &{1'b0, DataIn[31:NUM_SRC]};

    // Priority encoder: lowest-indexed active source wins.
    always_comb begin
        idx = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) idx = 5'(i);
        end
    end

    // Pending/enable next-state: a fresh edge beats a claim, which beats a W1C.
    always_comb begin
        pend_d   = pend_q;
        enable_d = enable_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend_set[i])
                pend_d[i] = 1'b1;
            else if (claim && (idx == 5'(i)))
                pend_d[i] = 1'b0;
            else if (wr_en && (Addr == ADDR_PEND) && DataIn[i])
                pend_d[i] = 1'b0;
        end
        if (wr_en && (Addr == ADDR_ENABLE))
            enable_d = DataIn[NUM_SRC-1:0];
    end

    // FSM next-state: signal, claim, then wait for end-of-interrupt.
    always_comb begin
        state_d      = state_q;
        in_service_d = in_service_q;
        unique case (state_q)
            IDLE: begin
                if (any_active) state_d = ASSERT;
            end
            ASSERT: begin
                if (claim) begin
                    state_d      = SERVICE;
                    in_service_d = idx;
                end else if (!any_active) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read mux uses pre-write register values so a combined read/write sees old data.
    always_comb begin
        rdata = 32'd0;
        unique case (Addr)
            ADDR_PEND:   rdata = {{(32 - NUM_SRC){1'b0}}, pend_q};
            ADDR_ENABLE: rdata = {{(32 - NUM_SRC){1'b0}}, enable_q};
            ADDR_VECTOR: begin
                if (state_q == ASSERT && any_active)
                    rdata = {1'b1, 26'd0, idx};
                else if (state_q == SERVICE)
                    rdata = {1'b0, 26'd0, in_service_q};
            end
            ADDR_STATE:  rdata = {29'd0, (state_q == SERVICE), state_q};
            default:     rdata = 32'd0;
        endcase
        data_out_d = rd_en ? rdata : 32'd0;
    end

    // State registers; prev_src resets high so a line low at release counts as an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            enable_q     <= '0;
            prev_src_q   <= '1;
            in_service_q <= 5'd0;
            irq_n_q      <= 1'b1;
            data_out_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            enable_q     <= enable_d;
            prev_src_q   <= IntrSrc_N;
            in_service_q <= in_service_d;
            irq_n_q      <= (state_q != ASSERT);
            data_out_q   <= data_out_d;
        end
    end

    assign DataOut = data_out_q;
    assign IRQ_N   = irq_n_q;

endmodule
